// File: rtl/piece_control_pkg.sv
// Purpose: shared definitions for the falling-piece controller (board size, states, action encoding).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package piece_control_pkg;

    // Board geometry in cells.
    localparam int BLOCKS_W = 10;
    localparam int BLOCKS_H = 20;

    // Collision/position field widths shared with the collision checkers.
    localparam int X_W   = 4;
    localparam int Y_W   = 5;
    localparam int ROT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_FALL  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // One-hot action selected for the current FALL cycle; all-zero means no action.
    typedef struct packed {
        logic rot;
        logic left;
        logic right;
        logic down;
    } action_t;

    // True when a piece at column x with width w still fits inside a board of width lim.
    function automatic logic fits_width(input logic [X_W-1:0] x,
                                        input logic [3:0]     w,
                                        input int             lim);
        return ({1'b0, x} + {1'b0, w}) <= (X_W+1)'(lim);
    endfunction

endpackage

// File: rtl/piece_ctrl_arb.sv
// Purpose: pending-gravity flag plus fixed-priority picker (rot > left > right > down) for FALL.
// Latency: action is combinational; a tick becomes a down request from the following cycle.
// Backpressure: none; unselected buttons are dropped, only the tick is remembered.
// Ports: fall = controller is in FALL; hold = controller in IDLE/LOCK/OVER (flag forced clear);
//        tick/btn_* = request pulses; act = one-hot chosen action.
module piece_ctrl_arb
    import piece_control_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    fall,
    input  logic    hold,
    input  logic    tick,
    input  logic    btn_rot,
    input  logic    btn_left,
    input  logic    btn_right,
    input  logic    btn_down,
    output action_t act
);

    logic pending;

    always_comb begin
        act = '0;
        if (fall) begin
            if (btn_rot)                   act.rot   = 1'b1;
            else if (btn_left)             act.left  = 1'b1;
            else if (btn_right)            act.right = 1'b1;
            else if (btn_down || pending)  act.down  = 1'b1;
        end
    end

    // A fresh tick outranks the clear so gravity arriving on the same cycle
    // as a down move is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pending <= 1'b0;
        else if (hold)     pending <= 1'b0;
        else if (tick)     pending <= 1'b1;
        else if (act.down) pending <= 1'b0;
    end

endmodule

// File: rtl/piece_control.sv
// Purpose: falling-piece state machine: spawn, move/rotate/drop, lock handshake, game over.
// Latency: accepted action visible on outputs one cycle later; SPAWN takes one cycle.
// Backpressure: lock_valid held in LOCK until lock_ready; inputs ignored meanwhile.
// Ports: start/piece_id spawn control; btn_*/tick requests; can_* collision results;
//        piece_next_w width after next rotation; lock_ready merge accept;
//        piece_* current piece, active/lock_valid/game_over state flags.
module piece_control #(
    parameter int BLOCKS_W = piece_control_pkg::BLOCKS_W,
    parameter int BLOCKS_H = piece_control_pkg::BLOCKS_H,
    parameter int SPAWN_X  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] piece_id,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       tick,
    input  logic       can_left,
    input  logic       can_right,
    input  logic       can_down,
    input  logic       can_rotate,
    input  logic [3:0] piece_next_w,
    input  logic       lock_ready,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic [2:0] piece_type,
    output logic       active,
    output logic       lock_valid,
    output logic       game_over
);
    import piece_control_pkg::*;

    state_t  state;
    action_t act;
    logic    rot_ok;
    logic    down_ok;

    piece_ctrl_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .fall      (state == ST_FALL),
        .hold      (state == ST_IDLE || state == ST_LOCK || state == ST_OVER),
        .tick      (tick),
        .btn_rot   (btn_rot),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .act       (act)
    );

    assign rot_ok  = can_rotate && fits_width(piece_x, piece_next_w, BLOCKS_W);
    // The floor is normally enforced by can_down; the row guard keeps y in range regardless.
    assign down_ok = can_down && (piece_y < Y_W'(BLOCKS_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            piece_x    <= '0;
            piece_y    <= '0;
            piece_rot  <= '0;
            piece_type <= '0;
            active     <= 1'b0;
            lock_valid <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state     <= ST_SPAWN;
                        game_over <= 1'b0;
                    end
                end
                ST_SPAWN: begin
                    piece_x    <= X_W'(SPAWN_X);
                    piece_y    <= '0;
                    piece_rot  <= '0;
                    piece_type <= piece_id;
                    state      <= ST_FALL;
                    active     <= 1'b1;
                end
                ST_FALL: begin
                    // A blocked request still consumes the cycle; nothing else runs.
                    if (act.rot) begin
                        if (rot_ok) piece_rot <= piece_rot + ROT_W'(1);
                    end else if (act.left) begin
                        if (can_left) piece_x <= piece_x - X_W'(1);
                    end else if (act.right) begin
                        if (can_right) piece_x <= piece_x + X_W'(1);
                    end else if (act.down) begin
                        if (down_ok) begin
                            piece_y <= piece_y + Y_W'(1);
                        end else begin
                            state      <= ST_LOCK;
                            active     <= 1'b0;
                            lock_valid <= 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (lock_ready) begin
                        lock_valid <= 1'b0;
                        if (piece_y != '0) begin
                            state <= ST_SPAWN;
                        end else begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    active     <= 1'b0;
                    lock_valid <= 1'b0;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_control.sv
// Purpose: randomized + directed bench for piece_control with a queue-based scoreboard.
// Latency: expected outputs are queued per cycle and compared on the following falling edge.
// Backpressure: lock_ready is randomly withheld to exercise the lock hold.
module tb_piece_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] piece_id = '0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
    logic       tick = 1'b0;
    logic       can_left = 1'b0, can_right = 1'b0, can_down = 1'b0, can_rotate = 1'b0;
    logic [3:0] piece_next_w = 4'd1;
    logic       lock_ready = 1'b0;

    logic [3:0] piece_x;
    logic [4:0] piece_y;
    logic [1:0] piece_rot;
    logic [2:0] piece_type;
    logic       active, lock_valid, game_over;

    always #5 clk = ~clk;

    piece_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .piece_id     (piece_id),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_rot      (btn_rot),
        .btn_down     (btn_down),
        .tick         (tick),
        .can_left     (can_left),
        .can_right    (can_right),
        .can_down     (can_down),
        .can_rotate   (can_rotate),
        .piece_next_w (piece_next_w),
        .lock_ready   (lock_ready),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .piece_rot    (piece_rot),
        .piece_type   (piece_type),
        .active       (active),
        .lock_valid   (lock_valid),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
        logic [1:0] rot;
        logic [2:0] typ;
        logic       act;
        logic       lv;
        logic       go;
    } snap_t;

    snap_t dut_s;
    assign dut_s = {piece_x, piece_y, piece_rot, piece_type, active, lock_valid, game_over};

    snap_t expq[$];
    string tagq[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: game described as a mode plus plain integer piece coordinates.
    localparam int M_IDLE = 0, M_SPAWN = 1, M_FALL = 2, M_LOCK = 3, M_OVER = 4;
    int m_mode = M_IDLE;
    int m_x = 0, m_y = 0, m_rot = 0, m_typ = 0;
    bit m_pend = 1'b0;

    function automatic snap_t mk(int x, int y, int rot, int typ, bit a, bit lv, bit g);
        snap_t s;
        s.x = 4'(x); s.y = 5'(y); s.rot = 2'(rot); s.typ = 3'(typ);
        s.act = a; s.lv = lv; s.go = g;
        return s;
    endfunction

    function automatic snap_t model_snap();
        return mk(m_x, m_y, m_rot, m_typ, m_mode == M_FALL, m_mode == M_LOCK, m_mode == M_OVER);
    endfunction

    task automatic chk(string name, snap_t got, snap_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d rot=%0d type=%0d active=%0b lock_valid=%0b game_over=%0b, want x=%0d y=%0d rot=%0d type=%0d active=%0b lock_valid=%0b game_over=%0b",
                     name, got.x, got.y, got.rot, got.typ, got.act, got.lv, got.go,
                     exp.x, exp.y, exp.rot, exp.typ, exp.act, exp.lv, exp.go);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit took_down;
        took_down = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_x = 0; m_y = 0; m_rot = 0; m_typ = 0; m_pend = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE, M_OVER: begin
                m_pend = 1'b0;
                if (start) m_mode = M_SPAWN;
            end
            M_SPAWN: begin
                m_x = 3; m_y = 0; m_rot = 0; m_typ = int'(piece_id);
                m_mode = M_FALL;
                if (tick) m_pend = 1'b1;
            end
            M_FALL: begin
                if (btn_rot) begin
                    if (can_rotate && (m_x + int'(piece_next_w) <= 10)) m_rot = (m_rot + 1) % 4;
                end else if (btn_left) begin
                    if (can_left) m_x = (m_x + 15) % 16;
                end else if (btn_right) begin
                    if (can_right) m_x = (m_x + 1) % 16;
                end else if (btn_down || m_pend) begin
                    took_down = 1'b1;
                    if (can_down && m_y < 19) m_y = m_y + 1;
                    else                      m_mode = M_LOCK;
                end
                if (tick)           m_pend = 1'b1;
                else if (took_down) m_pend = 1'b0;
            end
            M_LOCK: begin
                m_pend = 1'b0;
                if (lock_ready) m_mode = (m_y != 0) ? M_SPAWN : M_OVER;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Queue this cycle's expectation, let the edge happen, then drop the pulses.
    task automatic go(string tag);
        model_step();
        expq.push_back(model_snap());
        tagq.push_back(tag);
        @(negedge clk);
        #1;
        start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0;
        tick = 1'b0;
    endtask

    // Monitor: compares one queued expectation per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            snap_t e;
            string t;
            e = expq.pop_front();
            t = tagq.pop_front();
            chk(t, dut_s, e);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        go("reset0");
        go("reset1");
        chk("reset_state", dut_s, mk(0, 0, 0, 0, 0, 0, 0));

        // First start right after reset release.
        rst_n = 1'b1;
        start = 1'b1; piece_id = 3'd5;
        go("start");
        go("spawn");
        chk("spawn_load", dut_s, mk(3, 0, 0, 5, 1, 0, 0));

        // Rotate beats left in the same cycle.
        can_rotate = 1'b1; can_left = 1'b1; can_right = 1'b1; can_down = 1'b1;
        piece_next_w = 4'd3;
        btn_rot = 1'b1; btn_left = 1'b1;
        go("rot_over_left");
        chk("rot_over_left_val", dut_s, mk(3, 0, 1, 5, 1, 0, 0));

        for (int i = 0; i < 5; i++) begin
            btn_right = 1'b1;
            go("right");
        end
        btn_rot = 1'b1;
        go("rot_too_wide");
        chk("rot_blocked_width", dut_s, mk(8, 0, 1, 5, 1, 0, 0));
        piece_next_w = 4'd2;
        for (int i = 0; i < 3; i++) begin
            btn_rot = 1'b1;
            go("rot_wrap");
        end
        chk("rot_wraps", dut_s, mk(8, 0, 0, 5, 1, 0, 0));

        // Tick deferred behind left, then tick followed by btn_down gives one step.
        tick = 1'b1; btn_left = 1'b1;
        go("tick_left");
        go("pending_down");
        chk("tick_after_left", dut_s, mk(7, 1, 0, 5, 1, 0, 0));
        tick = 1'b1;
        go("tick_only");
        btn_down = 1'b1;
        go("btn_down_clears");
        go("idle");
        chk("single_down", dut_s, mk(7, 2, 0, 5, 1, 0, 0));

        for (int i = 0; i < 15; i++) begin
            btn_down = 1'b1;
            go("drop");
        end
        can_down = 1'b0; tick = 1'b1;
        go("tick_blocked");
        go("enter_lock");
        chk("lock_enter", dut_s, mk(7, 17, 0, 5, 0, 1, 0));
        lock_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; btn_left = 1'b1; btn_down = 1'b1; start = 1'b1;
            go("lock_hold");
        end
        chk("lock_frozen", dut_s, mk(7, 17, 0, 5, 0, 1, 0));
        lock_ready = 1'b1;
        go("lock_accept");
        chk("lock_to_spawn", dut_s, mk(7, 17, 0, 5, 0, 0, 0));
        lock_ready = 1'b0; piece_id = 3'd2;
        go("respawn");

        // Lock at the top row ends the game.
        btn_down = 1'b1;
        go("lock_top");
        lock_ready = 1'b1;
        go("over");
        chk("game_over", dut_s, mk(3, 0, 0, 2, 0, 0, 1));
        lock_ready = 1'b0;
        start = 1'b1; piece_id = 3'd6;
        go("restart");
        go("restart_spawn");
        btn_down = 1'b1;
        go("lock_again");
        chk("lock_again_val", dut_s, mk(3, 0, 0, 6, 0, 1, 0));

        // Asynchronous reset in the middle of LOCK.
        rst_n = 1'b0;
        #1;
        chk("reset_midlock", dut_s, mk(0, 0, 0, 0, 0, 0, 0));
        go("reset_hold");
        rst_n = 1'b1;
        start = 1'b1; piece_id = 3'd1;
        go("start_after_reset");
        go("spawn_after_reset");
        chk("spawn_after_reset_val", dut_s, mk(3, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 19) == 0);
            piece_id     = 3'($urandom);
            btn_rot      = ($urandom_range(0, 9) == 0);
            btn_left     = ($urandom_range(0, 6) == 0);
            btn_right    = ($urandom_range(0, 6) == 0);
            btn_down     = ($urandom_range(0, 9) == 0);
            tick         = ($urandom_range(0, 3) == 0);
            can_left     = (m_x > 0) && ($urandom_range(0, 3) != 0);
            can_right    = (m_x < 9) && ($urandom_range(0, 3) != 0);
            can_down     = (m_y < 19) && ($urandom_range(0, 7) != 0);
            can_rotate   = ($urandom_range(0, 2) != 0);
            piece_next_w = 4'($urandom_range(1, 4));
            lock_ready   = ($urandom_range(0, 2) == 0);
            go("random");
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
